// File: rtl/sc_grid_classifier_pkg.sv
// Shared types for the grid classifier: grid_state_t, default widths and the
// helper that merges two per-quantity classes into one.
package sc_grid_classifier_pkg;

  typedef enum logic [1:0] {
    GRID_NORMAL   = 2'd0,
    GRID_UNSTABLE = 2'd1,
    GRID_CRITICAL = 2'd2
  } grid_state_t;

  localparam int unsigned VW_DEF = 10;
  localparam int unsigned FW_DEF = 13;

  // Encoding 3 is illegal and is treated as CRITICAL, the safe side.
  function automatic grid_state_t grid_worse(input grid_state_t a, input grid_state_t b);
    if ((a != GRID_NORMAL && a != GRID_UNSTABLE) || (b != GRID_NORMAL && b != GRID_UNSTABLE))
      return GRID_CRITICAL;
    if (a == GRID_UNSTABLE || b == GRID_UNSTABLE)
      return GRID_UNSTABLE;
    return GRID_NORMAL;
  endfunction

endpackage

// File: rtl/sc_grid_classifier_if.sv
// Metering-sample input and grid-state output bundle of the grid classifier.
interface sc_grid_classifier_if
  import sc_grid_classifier_pkg::*;
#(
  parameter int unsigned VW = VW_DEF,
  parameter int unsigned FW = FW_DEF
);
  logic          sample_valid;
  logic [VW-1:0] v_rms;
  logic [FW-1:0] freq;
  grid_state_t   grid_state;
  logic          state_changed;
  logic          sensor_lost;

  modport master (
    output sample_valid, v_rms, freq,
    input  grid_state, state_changed, sensor_lost
  );

  modport slave (
    input  sample_valid, v_rms, freq,
    output grid_state, state_changed, sensor_lost
  );
endinterface

// File: rtl/sc_grid_classifier_band_check.sv
// Combinational window compare of one measured quantity against critical and
// unstable limits (inclusive), with an optional hysteresis-narrowed normal band.
module sc_band_check
  import sc_grid_classifier_pkg::*;
#(
  parameter int unsigned W       = 10,
  parameter int unsigned CRIT_LO = 176,
  parameter int unsigned UNST_LO = 198,
  parameter int unsigned UNST_HI = 242,
  parameter int unsigned CRIT_HI = 264,
  parameter int unsigned HYST    = 4
) (
  input  logic [W-1:0] i_x,
  input  logic         i_hyst_en,
  output grid_state_t  o_class
);

  localparam logic [W-1:0] C_CRIT_LO = W'(CRIT_LO);
  localparam logic [W-1:0] C_UNST_LO = W'(UNST_LO);
  localparam logic [W-1:0] C_UNST_HI = W'(UNST_HI);
  localparam logic [W-1:0] C_CRIT_HI = W'(CRIT_HI);
  localparam logic [W-1:0] C_HYST_LO = W'(UNST_LO + HYST);
  localparam logic [W-1:0] C_HYST_HI = W'(UNST_HI - HYST);

  always_comb begin
    o_class = GRID_NORMAL;
    if (i_x < C_CRIT_LO || i_x > C_CRIT_HI)
      o_class = GRID_CRITICAL;
    else if (i_x < C_UNST_LO || i_x > C_UNST_HI)
      o_class = GRID_UNSTABLE;
    else if (i_hyst_en && (i_x < C_HYST_LO || i_x > C_HYST_HI))
      o_class = GRID_UNSTABLE;
  end

endmodule

// File: rtl/sc_grid_classifier.sv
// Grid-quality classifier: fast escalation, debounced stepwise recovery with
// hysteresis, and a watchdog that forces CRITICAL when samples stop arriving.
module sc_grid_classifier
  import sc_grid_classifier_pkg::*;
#(
  parameter int unsigned VW          = VW_DEF,
  parameter int unsigned FW          = FW_DEF,
  parameter int unsigned V_CRIT_LO   = 176,
  parameter int unsigned V_UNST_LO   = 198,
  parameter int unsigned V_UNST_HI   = 242,
  parameter int unsigned V_CRIT_HI   = 264,
  parameter int unsigned F_CRIT_LO   = 5850,
  parameter int unsigned F_UNST_LO   = 5950,
  parameter int unsigned F_UNST_HI   = 6050,
  parameter int unsigned F_CRIT_HI   = 6150,
  parameter int unsigned V_HYST      = 4,
  parameter int unsigned F_HYST      = 10,
  parameter int unsigned UP_CNT      = 4,
  parameter int unsigned RECOVER_CNT = 64,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input logic                 clk,
  input logic                 reset,
  sc_grid_classifier_if.slave bus
);

  localparam int unsigned ESC_W = $clog2(UP_CNT + 1);
  localparam int unsigned REC_W = $clog2(RECOVER_CNT + 1);
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [ESC_W-1:0] ESC_MAX = ESC_W'(UP_CNT);
  localparam logic [REC_W-1:0] REC_MAX = REC_W'(RECOVER_CNT);
  localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT_CYC);
  localparam logic [WD_W-1:0]  WD_TRIP = WD_W'(TIMEOUT_CYC - 1);

  grid_state_t      r_state, w_state_nxt;
  logic [ESC_W-1:0] r_esc, w_esc_nxt, w_esc_inc;
  logic [REC_W-1:0] r_rec, w_rec_nxt, w_rec_inc;
  logic [WD_W-1:0]  r_wd, w_wd_nxt;
  logic             r_lost, w_lost_nxt;
  logic             r_changed;

  grid_state_t w_v_class, w_f_class, w_raw;
  logic        w_hyst_en;

  assign w_hyst_en = (r_state != GRID_NORMAL);

  sc_band_check #(
    .W(VW), .CRIT_LO(V_CRIT_LO), .UNST_LO(V_UNST_LO),
    .UNST_HI(V_UNST_HI), .CRIT_HI(V_CRIT_HI), .HYST(V_HYST)
  ) u_v_check (
    .i_x(bus.v_rms), .i_hyst_en(w_hyst_en), .o_class(w_v_class)
  );

  sc_band_check #(
    .W(FW), .CRIT_LO(F_CRIT_LO), .UNST_LO(F_UNST_LO),
    .UNST_HI(F_UNST_HI), .CRIT_HI(F_CRIT_HI), .HYST(F_HYST)
  ) u_f_check (
    .i_x(bus.freq), .i_hyst_en(w_hyst_en), .o_class(w_f_class)
  );

  assign w_raw     = grid_worse(w_v_class, w_f_class);
  assign w_esc_inc = (r_esc == ESC_MAX) ? r_esc : r_esc + 1'b1;
  assign w_rec_inc = (r_rec == REC_MAX) ? r_rec : r_rec + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_esc_nxt   = r_esc;
    w_rec_nxt   = r_rec;
    w_wd_nxt    = r_wd;
    w_lost_nxt  = r_lost;

    if (bus.sample_valid) begin
      w_wd_nxt   = '0;
      w_lost_nxt = 1'b0;
      if (w_raw == GRID_CRITICAL) begin
        w_state_nxt = GRID_CRITICAL;
        w_esc_nxt   = '0;
        w_rec_nxt   = '0;
      end else begin
        case (r_state)
          GRID_NORMAL: begin
            if (w_raw == GRID_UNSTABLE) begin
              w_esc_nxt = w_esc_inc;
              if (w_esc_inc == ESC_MAX) w_state_nxt = GRID_UNSTABLE;
            end else begin
              w_esc_nxt = '0;
            end
          end
          GRID_UNSTABLE: begin
            if (w_raw == GRID_NORMAL) begin
              w_rec_nxt = w_rec_inc;
              if (w_rec_inc == REC_MAX) w_state_nxt = GRID_NORMAL;
            end else begin
              w_rec_nxt = '0;
            end
          end
          default: begin
            // CRITICAL (and the illegal encoding) always step down to UNSTABLE first.
            w_rec_nxt = w_rec_inc;
            if (w_rec_inc == REC_MAX) w_state_nxt = GRID_UNSTABLE;
          end
        endcase
      end
    end else if (r_wd == WD_TRIP) begin
      w_wd_nxt    = WD_MAX;
      w_state_nxt = GRID_CRITICAL;
      w_lost_nxt  = 1'b1;
      w_rec_nxt   = '0;
    end else if (r_wd != WD_MAX) begin
      w_wd_nxt = r_wd + 1'b1;
    end

    if (w_state_nxt != r_state) begin
      w_esc_nxt = '0;
      w_rec_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= GRID_UNSTABLE;
      r_esc     <= '0;
      r_rec     <= '0;
      r_wd      <= '0;
      r_lost    <= 1'b0;
      r_changed <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_esc     <= w_esc_nxt;
      r_rec     <= w_rec_nxt;
      r_wd      <= w_wd_nxt;
      r_lost    <= w_lost_nxt;
      r_changed <= (w_state_nxt != r_state);
    end
  end

  assign bus.grid_state    = r_state;
  assign bus.state_changed = r_changed;
  assign bus.sensor_lost   = r_lost;

endmodule
